multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control unit of the multicycle MIPS CPU; sits directly upstream of the ALU-control decoder.
//  Moore FSM that sequences each instruction through fetch/decode/execute/memory/writeback.
//  Drives every datapath enable/mux select, plus the 2-bit aluop consumed by ALU control.
//  aluop encoding: 00 add (lw/sw/PC+4), 01 beq (sub), 11 bne, 10 decode from op/funct.
// PARAMETERS
//  STATE_W  4  width of state register / state_o port
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  op          in   6  opcode field of the instruction register (IR[31:26])
//  pcwrite     out  1  unconditional PC load
//  pcwritecond out  1  conditional PC load; datapath ANDs it with the ALU zero flag
//  iord        out  1  memory address select: 0 = PC, 1 = ALUOut
//  memread     out  1  memory read strobe
//  memwrite    out  1  memory write strobe
//  irwrite     out  1  instruction register load
//  memtoreg    out  1  register-file write-data select: 0 = ALUOut, 1 = MDR
//  regdst      out  1  destination register select: 0 = rt, 1 = rd
//  regwrite    out  1  register-file write enable
//  alusrca     out  1  ALU A select: 0 = PC, 1 = reg A
//  alusrcb     out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sext imm<<2
//  aluop       out  2  to ALU control, encoding as above
//  pcsource    out  2  PC next select: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  instr_done  out  1  one-cycle pulse in the final state of every instruction
//  illegal_op  out  1  sticky unsupported-opcode flag (macro only; tied 0 otherwise)
//  state_o     out  4  current state, for debug
// BEHAVIOUR
//  - Reset: asynchronous; state <= IDLE. In IDLE all outputs are 0. IDLE -> FETCH unconditionally on the next clk.
//  - Outputs are pure combinational decode of the state register (Moore); no output depends on op.
//  - Any output not listed for a state below is 0.
//  - State encoding and per-state outputs:
//    0 IDLE
//    1 FETCH: memread, irwrite, pcwrite; alusrcb=01; aluop=00; pcsource=00 -> DECODE
//    2 DECODE: alusrcb=11; aluop=00 (branch target into ALUOut). Dispatch on op:
//      lw 100011 / sw 101011 -> MEMADR;  R-type 000000 -> EXEC;  beq 000100 -> BEQ;
//      bne 000101 -> BNE;  j 000010 -> JUMP;
//      addi 001000 / andi 001100 / ori 001101 / xori 001110 / slti 001010 -> IEXEC;
//      any other op -> see CONFIGURATION
//    3 MEMADR: alusrca; alusrcb=10; aluop=00 -> MEMRD if op==lw, else MEMWR
//    4 MEMRD: memread; iord -> MEMWB
//    5 MEMWB: regwrite; memtoreg; regdst=0; instr_done -> FETCH
//    6 MEMWR: memwrite; iord; instr_done -> FETCH
//    7 EXEC: alusrca; alusrcb=00; aluop=10 -> RWB
//    8 RWB: regdst; regwrite; instr_done -> FETCH
//    9 BEQ: alusrca; alusrcb=00; aluop=01; pcwritecond; pcsource=01; instr_done -> FETCH
//    10 BNE: same as BEQ but aluop=11 -> FETCH
//    11 JUMP: pcwrite; pcsource=10; instr_done -> FETCH
//    12 IEXEC: alusrca; alusrcb=10; aluop=10 -> IWB
//    13 IWB: regdst=0; regwrite; memtoreg=0; instr_done -> FETCH
//    14 HALT: all outputs 0 except illegal_op; absorbing; exit only via reset
//    15 unused: -> IDLE on the next clk
//  - Latency in cycles, FETCH through final state: lw 5; sw 4; R-type 4; I-type ALU 4; beq/bne 3; j 3.
//  - op is sampled in DECODE and MEMADR only. IR loads at the end of FETCH, so op is stable from DECODE to instruction end.
//  - Reset mid-instruction: state goes to IDLE immediately. Write strobes (regwrite, memwrite, pcwrite, pcwritecond) deassert asynchronously, so no partial write is issued.
// CONFIGURATION
//  - ILLEGAL_OP_TRAP_EN defined: an unlisted op in DECODE -> HALT. illegal_op sets on entry to HALT and holds until reset. No instr_done for that instruction.
//  - ILLEGAL_OP_TRAP_EN undefined: an unlisted op in DECODE -> FETCH (executes as a NOP, no instr_done). HALT is unreachable; illegal_op is tied 0.
// TESTING
//  - Reset: hold rst_n=0 for 3 clk -> state_o=0, all outputs 0. Release -> state_o=1 next clk with memread=irwrite=pcwrite=1.
//  - lw (op=100011): state sequence 1,2,3,4,5 -> aluop=00 throughout; memtoreg=regwrite=1 and instr_done=1 only in state 5.
//  - R-type (op=000000): states 1,2,7,8 -> aluop=10 in state 7; regdst=regwrite=1 in state 8.
//  - beq/bne (000100 / 000101): states 1,2,9 / 1,2,10 -> aluop 01 / 11; pcwritecond=1; pcsource=01.
//  - ori (001101) then j (000010): states 1,2,12,13 then 1,2,11 -> aluop=10 in state 12; pcsource=10 with pcwrite in state 11.
//  - op=111111: with macro -> state 14, illegal_op=1 held 10 clk. Without macro -> back to state 1, no instr_done.
//  - Reset mid-instruction: assert rst_n low in state 4 -> state_o=0 and memread=0 with no clk edge.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle MIPS main control FSM (master) and the datapath (slave).
// The master drives every datapath enable/select plus debug state; the slave supplies the IR opcode.
interface multicycle_ctrl_fsm_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic               pcwrite;
  logic               pcwritecond;
  logic               iord;
  logic               memread;
  logic               memwrite;
  logic               irwrite;
  logic               memtoreg;
  logic               regdst;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         aluop;
  logic [1:0]         pcsource;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource, instr_done,
           illegal_op, state_o
  );

  modport slave (
    output op,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource, instr_done,
           illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Moore main control FSM of the multicycle MIPS CPU: fetch/decode/execute/memory/writeback sequencing.
// Optional macro ILLEGAL_OP_TRAP_EN: unlisted opcodes trap into an absorbing HALT with sticky illegal_op.
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  ctrl
);

  localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_RWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BEQ    = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_BNE    = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_IEXEC  = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_IWB    = STATE_W'(13);
  localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(14);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  logic [STATE_W-1:0] state_q, state_d;

  // Outputs decode state_q only, so the async reset clears every write strobe without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW:                               state_d = S_MEMADR;
          OP_RTYPE:                                   state_d = S_EXEC;
          OP_BEQ:                                     state_d = S_BEQ;
          OP_BNE:                                     state_d = S_BNE;
          OP_J:                                       state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_IEXEC;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                                    state_d = S_HALT;
`else
          default:                                    state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = (ctrl.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_BNE:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, instr_done;
  logic [1:0] alusrcb, aluop, pcsource;

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      // Branch target computed speculatively into ALUOut while the opcode is decoded.
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrca     = 1'b1;
        aluop       = (state_q == S_BEQ) ? 2'b01 : 2'b11;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b10;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  // Sets together with the HALT entry and only reset clears it.
  always_comb illegal_d = illegal_q | (state_d == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign ctrl.illegal_op = illegal_q;
`else
  assign ctrl.illegal_op = 1'b0;
`endif

  assign ctrl.pcwrite     = pcwrite;
  assign ctrl.pcwritecond = pcwritecond;
  assign ctrl.iord        = iord;
  assign ctrl.memread     = memread;
  assign ctrl.memwrite    = memwrite;
  assign ctrl.irwrite     = irwrite;
  assign ctrl.memtoreg    = memtoreg;
  assign ctrl.regdst      = regdst;
  assign ctrl.regwrite    = regwrite;
  assign ctrl.alusrca     = alusrca;
  assign ctrl.alusrcb     = alusrcb;
  assign ctrl.aluop       = aluop;
  assign ctrl.pcsource    = pcsource;
  assign ctrl.instr_done  = instr_done;
  assign ctrl.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed and random instruction streams checked against an
// instruction-level model of the state walk and per-state control outputs.
module tb_multicycle_ctrl_fsm;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.STATE_W(W)) bus ();

  multicycle_ctrl_fsm #(.STATE_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus.master)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] observed_outs();
    return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
            bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
            bus.alusrcb, bus.aluop, bus.pcsource, bus.instr_done, bus.illegal_op};
  endfunction

  // Control outputs written straight from the per-state table of the datasheet.
  function automatic logic [18:0] spec_outs(input int s, input bit ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, done;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, done} = '0;
    {asb, aop, psrc} = '0;
    case (s)
      1:  begin mr = 1; irw = 1; pcw = 1; asb = 2'b01; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; done = 1; end
      6:  begin mw = 1; iord = 1; done = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rd = 1; rw = 1; done = 1; end
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
      10: begin asa = 1; aop = 2'b11; pcwc = 1; psrc = 2'b01; done = 1; end
      11: begin pcw = 1; psrc = 2'b10; done = 1; end
      12: begin asa = 1; asb = 2'b10; aop = 2'b10; end
      13: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  // Expected state walk of one instruction, FETCH onward.
  task automatic plan(input logic [5:0] op);
    exp_q.push_back(W'(1));
    exp_q.push_back(W'(2));
    case (op)
      6'b100011: begin exp_q.push_back(W'(3)); exp_q.push_back(W'(4)); exp_q.push_back(W'(5)); end
      6'b101011: begin exp_q.push_back(W'(3)); exp_q.push_back(W'(6)); end
      6'b000000: begin exp_q.push_back(W'(7)); exp_q.push_back(W'(8)); end
      6'b000100: exp_q.push_back(W'(9));
      6'b000101: exp_q.push_back(W'(10));
      6'b000010: exp_q.push_back(W'(11));
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010:
        begin exp_q.push_back(W'(12)); exp_q.push_back(W'(13)); end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 11; i++) exp_q.push_back(W'(14));
`endif
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Entered and left at a negedge with the DUT expected in FETCH.
  task automatic run_instr(input logic [5:0] op, input string tag);
    int s;
    plan(op);
    while (exp_q.size() > 0) begin
      s = int'(exp_q.pop_front());
      check({tag, "_state"}, 32'(bus.state_o), 32'(s));
      check({tag, "_outs"}, 32'(observed_outs()), 32'(spec_outs(s, s == 14)));
      if (s == 1) bus.op = op;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic [5:0] legal_ops[11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001110,
                                6'b001010};

  initial begin
    logic [5:0] rop;
    bus.op = 6'b111111;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(bus.state_o), 32'd0);
    check("reset_outs", 32'(observed_outs()), 32'd0);

    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    run_instr(6'b100011, "lw");
    run_instr(6'b000000, "rtype");
    run_instr(6'b000100, "beq");
    run_instr(6'b000101, "bne");
    run_instr(6'b001101, "ori");
    run_instr(6'b000010, "j");
    run_instr(6'b101011, "sw");
    run_instr(6'b001000, "addi");
    run_instr(6'b001100, "andi");
    run_instr(6'b001110, "xori");
    run_instr(6'b001010, "slti");
`ifndef ILLEGAL_OP_TRAP_EN
    run_instr(6'b111111, "illegal_nop");
`endif

    for (int n = 0; n < 40; n++) begin
      rop = legal_ops[$urandom_range(0, 10)];
`ifndef ILLEGAL_OP_TRAP_EN
      if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(0, 63));
`endif
      run_instr(rop, "rand");
    end

    // Reset asserted inside MEMRD must clear state and strobes before any clock edge.
    bus.op = 6'b100011;
    for (int s = 1; s <= 4; s++) begin
      check("mid_walk", 32'(bus.state_o), 32'(s));
      if (s < 4) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_state", 32'(bus.state_o), 32'd0);
    check("mid_reset_memread", 32'(bus.memread), 32'd0);
    check("mid_reset_outs", 32'(observed_outs()), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_instr(6'b000010, "post_reset_j");

`ifdef ILLEGAL_OP_TRAP_EN
    run_instr(6'b111111, "halt");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
